// File: rtl/mod_counter.sv
// mod_counter: modulo-MODULUS up/down counter with load, terminal count and wrap pulse.
// Defining GRAY_OUT_EN adds a Gray-coded view of the count.
module mod_counter #(
   parameter int WIDTH   = 4,
   parameter int MODULUS = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] count,
   output logic             tc,
   output logic             wrap
`ifdef GRAY_OUT_EN
   ,
   output logic [WIDTH-1:0] gray
`endif
);
   localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);
   logic [WIDTH-1:0] next_count;
   logic             next_wrap;
   logic             at_max, at_zero;
   assign at_max  = count == MAX;
   assign at_zero = count == '0;
   assign tc      = up ? at_max : at_zero;
   // Boundary compares select the wrapped value, so +1 never passes MAX.
   always_comb begin
      next_count = count;
      next_wrap  = 1'b0;
      if (load) begin
         next_count = din > MAX ? MAX : din;
      end else if (en) begin
         next_count = up ? (at_max ? '0 : count + 1'b1) : (at_zero ? MAX : count - 1'b1);
         next_wrap  = up ? at_max : at_zero;
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
         wrap  <= 1'b0;
      end else begin
         count <= next_count;
         wrap  <= next_wrap;
      end
   end
`ifdef GRAY_OUT_EN
   assign gray = count ^ (count >> 1);
`endif
endmodule

// File: tb/tb_mod_counter.sv
// tb_mod_counter: randomized and directed checks of mod_counter against a modular-arithmetic model.
module tb_mod_counter;
   localparam int W = 4;
   localparam int MOD = 10;
   logic clk = 0;
   logic rst = 1, en = 0, up = 1, load = 0;
   logic [W-1:0] din = '0;
   logic [W-1:0] count;
   logic tc, wrap;
   int vectors = 0, miscompares = 0;
   int m_count = 0;
   bit m_wrap = 0, valid = 0;
   always #5 clk = ~clk;
`ifdef GRAY_OUT_EN
   logic [W-1:0] gray, g_count, g_gray;
   logic g_tc, g_wrap;
   mod_counter #(.WIDTH(W), .MODULUS(MOD)) dut (.clk(clk), .rst(rst), .en(en), .up(up), .load(load),
      .din(din), .count(count), .tc(tc), .wrap(wrap), .gray(gray));
   mod_counter #(.WIDTH(W), .MODULUS(16)) dut16 (.clk(clk), .rst(rst), .en(1'b1), .up(1'b1), .load(1'b0),
      .din('0), .count(g_count), .tc(g_tc), .wrap(g_wrap), .gray(g_gray));
`else
   mod_counter #(.WIDTH(W), .MODULUS(MOD)) dut (.clk(clk), .rst(rst), .en(en), .up(up), .load(load),
      .din(din), .count(count), .tc(tc), .wrap(wrap));
`endif

   task automatic check(input string name, input int got, input int exp);
      vectors++;
      if (got != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
      end
   endtask

   // Reference: next count from modular arithmetic on the sampled inputs.
   always @(posedge clk) begin
      if (rst) begin
         m_count = 0; m_wrap = 0; valid = 1;
      end else if (load) begin
         m_count = (din < MOD) ? int'(din) : MOD - 1; m_wrap = 0;
      end else if (en) begin
         m_wrap  = up ? (m_count + 1 == MOD) : (m_count == 0);
         m_count = up ? (m_count + 1) % MOD : (m_count + MOD - 1) % MOD;
      end else m_wrap = 0;
   end

   always @(negedge clk) begin
      if (valid) begin
         check("count", int'(count), m_count);
         check("wrap", int'(wrap), int'(m_wrap));
         check("tc", int'(tc), int'((up && m_count == MOD - 1) || (!up && m_count == 0)));
`ifdef GRAY_OUT_EN
         check("gray", int'(gray), m_count ^ (m_count >> 1));
`endif
      end
   end

`ifdef GRAY_OUT_EN
   logic [W-1:0] prev_g;
   bit have_prev = 0;
   always @(negedge clk) begin
      if (rst) have_prev = 0;
      else begin
         if (have_prev) check("gray16_onebit", $countones(g_gray ^ prev_g), 1);
         prev_g = g_gray; have_prev = 1;
      end
   end
`endif

   task automatic apply(input logic r, input logic l, input logic e, input logic u, input int d);
      rst = r; load = l; en = e; up = u; din = W'(d);
      @(posedge clk); #1;
   endtask

   initial begin
      @(posedge clk); #1;
      apply(1, 0, 0, 1, 0);
      check("reset_count", int'(count), 0);
      check("reset_wrap", int'(wrap), 0);
      check("reset_tc_up", int'(tc), 0);
      up = 0; #1;
      check("reset_tc_down", int'(tc), 1);
      for (int i = 1; i <= 12; i++) begin
         apply(0, 0, 1, 1, 0);
         check("up_count", int'(count), i % 10);
         check("up_wrap", int'(wrap), int'(i == 10));
         check("up_tc", int'(tc), int'(i == 9));
      end
      apply(1, 0, 0, 0, 0);
      check("down_tc_at0", int'(tc), 1);
      apply(0, 0, 1, 0, 0);
      check("down_9", int'(count), 9); check("down_wrap9", int'(wrap), 1);
      apply(0, 0, 1, 0, 0);
      check("down_8", int'(count), 8); check("down_wrap8", int'(wrap), 0);
      apply(0, 0, 1, 0, 0);
      check("down_7", int'(count), 7);
      apply(0, 1, 1, 1, 5);
      check("load5", int'(count), 5); check("load5_wrap", int'(wrap), 0);
      apply(0, 1, 1, 1, 13);
      check("load_clamp", int'(count), 9); check("clamp_wrap", int'(wrap), 0);
      apply(0, 1, 0, 1, 3);
      apply(0, 0, 1, 1, 0);
      check("to4", int'(count), 4);
      apply(1, 1, 1, 1, 7);
      check("rst_wins", int'(count), 0); check("rst_wins_wrap", int'(wrap), 0);
      apply(0, 0, 1, 1, 0);
      check("resume", int'(count), 1);
      apply(0, 1, 0, 1, 6);
      for (int i = 0; i < 5; i++) begin
         apply(0, 0, 0, i[0], 0);
         check("hold", int'(count), 6); check("hold_wrap", int'(wrap), 0);
         check("hold_tc", int'(tc), 0);
      end
      apply(0, 1, 0, 1, 9);
      check("tc9_up", int'(tc), 1); up = 0; #1; check("tc9_down", int'(tc), 0);
      apply(0, 1, 0, 0, 0);
      check("tc0_down", int'(tc), 1); up = 1; #1; check("tc0_up", int'(tc), 0);
      for (int i = 0; i < 2000; i++)
         apply($urandom_range(99) == 0, $urandom_range(9) == 0, $urandom_range(9) < 7,
               1'($urandom), int'($urandom_range(15)));
      @(negedge clk); #1;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
